// File: rtl/graph_partition_loader.sv
`default_nettype none
// ============================================================================
// Module   : graph_partition_loader
// Purpose  : Builds per-partition source/out-degree/destination arrays from a
//            serial edge stream and publishes them to a consumer.
//            Optional LOADER_DEDUP_EN drops edges whose destination is already
//            stored for the same source node.
// Revision : 1.0 - initial release
// ============================================================================
module graph_partition_loader #(
    parameter int NUM_PARTITIONS     = 1,
    parameter int NODES_IN_PARTITION = 4,
    parameter int MAX_OUT_DEGREE     = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        edge_valid,
    output logic        edge_ready,
    input  logic [31:0] edge_src,
    input  logic [31:0] edge_dst,
    input  logic        edge_last,
    output logic [NUM_PARTITIONS-1:0][NODES_IN_PARTITION-1:0][31:0] source_id,
    output logic [NUM_PARTITIONS-1:0][NODES_IN_PARTITION-1:0][31:0] out_degree,
    output logic [NUM_PARTITIONS-1:0][NODES_IN_PARTITION-1:0][MAX_OUT_DEGREE-1:0][31:0] dest_id,
    output logic        graph_valid,
    input  logic        graph_ack,
    output logic        overflow_err,
    output logic        range_err
);

    localparam int TOTAL = NUM_PARTITIONS * NODES_IN_PARTITION;
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int DW    = $clog2(MAX_OUT_DEGREE + 1);
    localparam int SW    = (MAX_OUT_DEGREE > 1) ? $clog2(MAX_OUT_DEGREE) : 1;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        LOAD    = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Node storage is kept flat by global node id, so src indexes it directly
    logic [DW-1:0] deg  [TOTAL];
    logic [31:0]   dest [TOTAL][MAX_OUT_DEGREE];

    logic          accept;
    logic          in_range;
    logic [IW-1:0] idx;
    logic [DW-1:0] cur_deg;
    logic          has_room;
    logic          is_dup;

    assign accept   = edge_valid && edge_ready;
    assign in_range = edge_src < 32'(TOTAL);
    assign idx      = edge_src[IW-1:0];
    assign cur_deg  = deg[idx];
    assign has_room = cur_deg < DW'(MAX_OUT_DEGREE);

`ifdef LOADER_DEDUP_EN
    always_comb begin
        is_dup = 1'b0;
        for (int j = 0; j < MAX_OUT_DEGREE; j++) begin
            if (in_range && (DW'(j) < cur_deg) && (dest[idx][j] == edge_dst)) begin
                is_dup = 1'b1;
            end
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        edge_ready  = 1'b0;
        graph_valid = 1'b0;
        unique case (state)
            CLEAR: begin
                next_state = LOAD;
            end
            LOAD: begin
                edge_ready = 1'b1;
                if (edge_valid && edge_last) begin
                    next_state = PUBLISH;
                end
            end
            PUBLISH: begin
                graph_valid = 1'b1;
                if (graph_ack) begin
                    next_state = CLEAR;
                end
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_err <= 1'b0;
            range_err    <= 1'b0;
            for (int i = 0; i < TOTAL; i++) begin
                deg[i] <= '0;
                for (int j = 0; j < MAX_OUT_DEGREE; j++) begin
                    dest[i][j] <= '0;
                end
            end
        end else if (state == CLEAR) begin
            overflow_err <= 1'b0;
            range_err    <= 1'b0;
            for (int i = 0; i < TOTAL; i++) begin
                deg[i] <= '0;
                for (int j = 0; j < MAX_OUT_DEGREE; j++) begin
                    dest[i][j] <= '0;
                end
            end
        end else if (accept) begin
            if (!in_range) begin
                range_err <= 1'b1;
            end else if (is_dup) begin
                deg[idx] <= cur_deg;
            end else if (has_room) begin
                dest[idx][cur_deg[SW-1:0]] <= edge_dst;
                deg[idx]                   <= cur_deg + 1'b1;
            end else begin
                overflow_err <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PARTITIONS; p++) begin : g_part
        for (genvar n = 0; n < NODES_IN_PARTITION; n++) begin : g_node
            assign source_id[p][n]  = 32'(p * NODES_IN_PARTITION + n);
            assign out_degree[p][n] = 32'(deg[p * NODES_IN_PARTITION + n]);
            for (genvar d = 0; d < MAX_OUT_DEGREE; d++) begin : g_slot
                assign dest_id[p][n][d] = dest[p * NODES_IN_PARTITION + n][d];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_graph_partition_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_graph_partition_loader
// Purpose  : Directed self-checking bench for graph_partition_loader with a
//            per-cycle reference model (P=2, N=4, D=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_graph_partition_loader;

    localparam int P = 2;
    localparam int N = 4;
    localparam int D = 3;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        edge_valid = 1'b0;
    logic        edge_last  = 1'b0;
    logic        graph_ack  = 1'b0;
    logic [31:0] edge_src   = '0;
    logic [31:0] edge_dst   = '0;
    logic        edge_ready;
    logic        graph_valid;
    logic        overflow_err;
    logic        range_err;
    logic [P-1:0][N-1:0][31:0]         source_id;
    logic [P-1:0][N-1:0][31:0]         out_degree;
    logic [P-1:0][N-1:0][D-1:0][31:0]  dest_id;

    int n_cmp = 0;
    int n_bad = 0;

    graph_partition_loader #(
        .NUM_PARTITIONS    (P),
        .NODES_IN_PARTITION(N),
        .MAX_OUT_DEGREE    (D)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .edge_valid  (edge_valid),
        .edge_ready  (edge_ready),
        .edge_src    (edge_src),
        .edge_dst    (edge_dst),
        .edge_last   (edge_last),
        .source_id   (source_id),
        .out_degree  (out_degree),
        .dest_id     (dest_id),
        .graph_valid (graph_valid),
        .graph_ack   (graph_ack),
        .overflow_err(overflow_err),
        .range_err   (range_err)
    );

    always #5 clock = ~clock;

    // Reference model: phase 0 = clearing, 1 = loading, 2 = published
    int          m_phase = 0;
    int unsigned m_deg  [P][N];
    logic [31:0] m_dest [P][N][D];
    bit          m_ovf = 1'b0;
    bit          m_rng = 1'b0;

    function automatic void model_clear();
        for (int p = 0; p < P; p++)
            for (int n = 0; n < N; n++) begin
                m_deg[p][n] = 0;
                for (int d = 0; d < D; d++) m_dest[p][n][d] = '0;
            end
        m_ovf = 1'b0;
        m_rng = 1'b0;
    endfunction

    function automatic void model_edge(input int unsigned src, input logic [31:0] dst);
        int unsigned p;
        int unsigned n;
        bit dup;
        if (src >= P * N) begin
            m_rng = 1'b1;
            return;
        end
        p   = src / N;
        n   = src % N;
        dup = 1'b0;
`ifdef LOADER_DEDUP_EN
        for (int j = 0; j < int'(m_deg[p][n]); j++)
            if (m_dest[p][n][j] == dst) dup = 1'b1;
`endif
        if (dup) return;
        if (m_deg[p][n] < D) begin
            m_dest[p][n][m_deg[p][n]] = dst;
            m_deg[p][n]++;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            model_clear();
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    model_clear();
                    m_phase = 1;
                end
                1: if (edge_valid) begin
                    model_edge(edge_src, edge_dst);
                    if (edge_last) m_phase = 2;
                end
                default: if (graph_ack) m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("edge_ready", {31'd0, edge_ready}, {31'd0, m_phase == 1});
        chk("graph_valid", {31'd0, graph_valid}, {31'd0, m_phase == 2});
        chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
        chk("range_err", {31'd0, range_err}, {31'd0, m_rng});
        for (int p = 0; p < P; p++)
            for (int n = 0; n < N; n++) begin
                chk($sformatf("source_id[%0d][%0d]", p, n), source_id[p][n], p * N + n);
                chk($sformatf("out_degree[%0d][%0d]", p, n), out_degree[p][n], m_deg[p][n]);
                for (int d = 0; d < D; d++)
                    chk($sformatf("dest_id[%0d][%0d][%0d]", p, n, d), dest_id[p][n][d], m_dest[p][n][d]);
            end
    end

    task automatic send(input logic [31:0] s, input logic [31:0] d, input logic l);
        edge_valid = 1'b1;
        edge_src   = s;
        edge_dst   = d;
        edge_last  = l;
        @(posedge clock);
        #1;
        edge_valid = 1'b0;
        edge_last  = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!edge_ready && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("wait_ready", {31'd0, edge_ready}, 32'd1);
    endtask

    // Ack at edge m: valid drops after m, CLEAR runs, ready rises after m+1
    task automatic do_ack();
        graph_ack = 1'b1;
        @(posedge clock);
        #1;
        graph_ack = 1'b0;
        chk("ack_valid_low", {31'd0, graph_valid}, 32'd0);
        chk("ack_ready_low", {31'd0, edge_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk("ack_ready_high", {31'd0, edge_ready}, 32'd1);
        chk("ack_ovf_clear", {31'd0, overflow_err}, 32'd0);
        chk("ack_rng_clear", {31'd0, range_err}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp_deg [4];
        int exp_dst [4][3];
        exp_deg = '{2, 1, 3, 1};
        exp_dst = '{'{1, 2, 0}, '{3, 0, 0}, '{0, 1, 3}, '{2, 0, 0}};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, edge_ready}, 32'd0);
        chk("rst_valid", {31'd0, graph_valid}, 32'd0);
        chk("rst_src_id", source_id[1][2], 32'd6);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("clear_then_load", {31'd0, edge_ready}, 32'd1);

        // Reference graph, back-to-back beats including same-node runs
        send(0, 1, 0); send(0, 2, 0); send(1, 3, 0);
        send(2, 0, 0); send(2, 1, 0); send(2, 3, 0);
        send(3, 2, 1);
        chk("pub_valid", {31'd0, graph_valid}, 32'd1);
        chk("pub_ready", {31'd0, edge_ready}, 32'd0);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("lit_deg[%0d]", n), out_degree[0][n], exp_deg[n]);
            chk($sformatf("model_deg[%0d]", n), m_deg[0][n], exp_deg[n]);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("lit_dst[%0d][%0d]", n, d), dest_id[0][n][d], exp_dst[n][d]);
                chk($sformatf("model_dst[%0d][%0d]", n, d), m_dest[0][n][d], exp_dst[n][d]);
            end
        end
        repeat (3) @(posedge clock);
        #1;
        do_ack();

        // Overflow on a full node
        send(2, 10, 0); send(2, 11, 0); send(2, 12, 0); send(2, 13, 1);
        chk("ovf_deg", out_degree[0][2], 32'd3);
        chk("ovf_d0", dest_id[0][2][0], 32'd10);
        chk("ovf_d2", dest_id[0][2][2], 32'd12);
        chk("ovf_flag", {31'd0, overflow_err}, 32'd1);
        chk("ovf_model", {31'd0, m_ovf}, 32'd1);
        chk("ovf_rng", {31'd0, range_err}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        do_ack();

        // Range errors, including the first out-of-range id P*N
        send(8, 1, 0); send(9, 2, 1);
        chk("rng_flag", {31'd0, range_err}, 32'd1);
        chk("rng_model", {31'd0, m_rng}, 32'd1);
        for (int p = 0; p < P; p++)
            for (int n = 0; n < N; n++)
                chk($sformatf("rng_deg[%0d][%0d]", p, n), out_degree[p][n], 32'd0);
        do_ack();

        // Duplicate edge
        send(1, 3, 0); send(1, 3, 1);
`ifdef LOADER_DEDUP_EN
        chk("dup_deg", out_degree[0][1], 32'd1);
        chk("dup_d1", dest_id[0][1][1], 32'd0);
`else
        chk("dup_deg", out_degree[0][1], 32'd2);
        chk("dup_d1", dest_id[0][1][1], 32'd3);
`endif
        do_ack();

        // Partition 1, unchecked dst, ack ignored while loading
        graph_ack = 1'b1;
        send(6, 32'hFFFF_FFFF, 0);
        graph_ack = 1'b0;
        chk("ack_in_load", {31'd0, edge_ready}, 32'd1);
        send(5, 0, 1);
        chk("p1_deg", out_degree[1][1], 32'd1);
        chk("p1_dst", dest_id[1][1][0], 32'd0);
        chk("p1_bigdst", dest_id[1][2][0], 32'hFFFF_FFFF);
        do_ack();

        // Single-beat graph, then reset mid-LOAD
        send(4, 7, 1);
        chk("single_deg", out_degree[1][0], 32'd1);
        do_ack();
        send(0, 1, 0); send(3, 2, 0);
        reset_n = 1'b0;
        #1;
        chk("rstl_deg", out_degree[0][0], 32'd0);
        chk("rstl_valid", {31'd0, graph_valid}, 32'd0);
        chk("rstl_ready", {31'd0, edge_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("rel_clear", {31'd0, edge_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk("rel_load", {31'd0, edge_ready}, 32'd1);
        send(3, 2, 1);
        chk("after_rst_d0", out_degree[0][0], 32'd0);
        chk("after_rst_d3", out_degree[0][3], 32'd1);

        // Reset mid-PUBLISH
        reset_n = 1'b0;
        #1;
        chk("rstp_valid", {31'd0, graph_valid}, 32'd0);
        chk("rstp_deg", out_degree[0][3], 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_ready();
        repeat (2) @(posedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
